// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register bank: NUM_REGS word registers, the last one a
// read-only count of committed OKAY writes. All registers mirrored on regs_out.
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic                           s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic                           s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    localparam int NB      = DATA_WIDTH / 8;
    localparam int CNT_IDX = NUM_REGS - 1;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t                r_wstate;
    w_state_t                w_wstate_next;
    r_state_t                r_rstate;
    r_state_t                w_rstate_next;

    logic                    r_aw_held;
    logic                    r_w_held;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NB-1:0]           r_wstrb;
    logic                    r_bresp;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_rresp;
    logic [DATA_WIDTH-1:0]   r_count;

    logic [DATA_WIDTH-1:0]   w_regs [NUM_REGS];
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_ar_hs;
    logic                    w_commit;
    logic                    w_wr_legal;
    logic                    w_wr_ok;
    logic [31:0]             w_wr_idx;
    logic                    w_rd_legal;
    logic [31:0]             w_rd_idx;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (32'(a[ADDR_WIDTH-1:2]) < 32'(NUM_REGS));
    endfunction

    // ---------------- write path ----------------
    assign s_axi_awready = (r_wstate == W_IDLE) && !r_aw_held;
    assign s_axi_wready  = (r_wstate == W_IDLE) && !r_w_held;
    assign s_axi_bvalid  = (r_wstate == W_RESP);
    assign s_axi_bresp   = r_bresp;

    assign w_aw_hs    = s_axi_awvalid && s_axi_awready;
    assign w_w_hs     = s_axi_wvalid && s_axi_wready;
    assign w_commit   = (r_wstate == W_IDLE) && r_aw_held && r_w_held;
    assign w_wr_idx   = 32'(r_awaddr[ADDR_WIDTH-1:2]);
    assign w_wr_legal = addr_legal(r_awaddr);
    // The counter slot answers writes with an error, like an unmapped address.
    assign w_wr_ok    = w_wr_legal && (w_wr_idx != 32'(CNT_IDX));

    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_commit) w_wstate_next = W_RESP;
            W_RESP:  if (s_axi_bready) w_wstate_next = W_IDLE;
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) r_wstate <= W_IDLE;
        else              r_wstate <= w_wstate_next;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_axi_awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= !w_wr_ok;
            end
        end
    end

    // ---------------- register storage ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS - 1; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] r_q;
            always_ff @(posedge s_axi_aclk) begin
                if (s_axi_areset) begin
                    r_q <= '0;
                end else if (w_commit && w_wr_ok && (w_wr_idx == gi)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (r_wstrb[b]) r_q[b*8 +: 8] <= r_wdata[b*8 +: 8];
                    end
                end
            end
            assign w_regs[gi] = r_q;
        end

        for (gi = 0; gi < NUM_REGS; gi++) begin : g_out
            assign regs_out[gi*DATA_WIDTH +: DATA_WIDTH] = w_regs[gi];
        end
    endgenerate

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset)             r_count <= '0;
        else if (w_commit && w_wr_ok) r_count <= r_count + DATA_WIDTH'(1);
    end
    assign w_regs[CNT_IDX] = r_count;

    // ---------------- read path ----------------
    assign s_axi_arready = (r_rstate == R_IDLE);
    assign s_axi_rvalid  = (r_rstate == R_DATA);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    assign w_ar_hs    = s_axi_arvalid && s_axi_arready;
    assign w_rd_idx   = 32'(s_axi_araddr[ADDR_WIDTH-1:2]);
    assign w_rd_legal = addr_legal(s_axi_araddr);

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_idx == 32'(i)) w_rd_data = w_regs[i];
        end
    end

    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_next = R_DATA;
            R_DATA:  if (s_axi_rready) w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) r_rstate <= R_IDLE;
        else              r_rstate <= w_rstate_next;
    end

    // Sampled from pre-commit values, so a read racing a commit sees old data.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rdata <= '0;
            r_rresp <= 1'b0;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_legal ? w_rd_data : '0;
            r_rresp <= !w_rd_legal;
        end
    end

endmodule
